// File: rtl/vga_fb_streamer.sv
// 640x480@60 VGA timing generator that streams a double-buffered 320x240 RGB444
// frame buffer, upscaled 2x, as a de/x/y/RGB pixel stream with hsync/vsync.
module vga_fb_streamer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              rd_bank,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    output logic              de_out,
    output logic [9:0]        x_out,
    output logic [9:0]        y_out,
    output logic [3:0]        r_out,
    output logic [3:0]        g_out,
    output logic [3:0]        b_out,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_RES);
    localparam logic [9:0] V_ACT    = 10'(V_RES);
    localparam logic [9:0] HS_START = 10'(H_RES + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_RES + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_RES + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_RES + V_FP + V_SYNC);

    localparam logic [ADDR_W-1:0] BANK_SIZE = ADDR_W'(FB_W * FB_H);
    localparam logic [ADDR_W-1:0] LINE_SIZE = ADDR_W'(FB_W);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       end_of_frame;
    logic       pending;

    assign h_wrap       = (h_cnt == H_LAST);
    assign end_of_frame = h_wrap && (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Bank only flips on the last cycle of a frame so every frame reads one bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_bank  <= 1'b0;
            pending  <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            if (end_of_frame && (pending || swap_req)) begin
                rd_bank  <= ~rd_bank;
                pending  <= 1'b0;
                swap_ack <= 1'b1;
            end else if (swap_req) begin
                pending <= 1'b1;
            end
        end
    end

    // Stage 0: frame-buffer address straight from the counters
    logic              act_p0;
    logic              hs_p0;
    logic              vs_p0;
    logic [ADDR_W-1:0] addr_p0;

    always_comb begin
        act_p0  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_p0   = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_p0   = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        addr_p0 = '0;
        if (act_p0) begin
            addr_p0 = (rd_bank ? BANK_SIZE : '0)
                    + ADDR_W'(v_cnt >> 1) * LINE_SIZE
                    + ADDR_W'(h_cnt >> 1);
        end
    end

    assign rd_en   = act_p0;
    assign rd_addr = addr_p0;

    // Stage 1: align position and syncs with the memory read latency
    logic       vld_p1;
    logic [9:0] h_p1;
    logic [9:0] v_p1;
    logic       hs_p1;
    logic       vs_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            h_p1   <= '0;
            v_p1   <= '0;
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
        end else begin
            vld_p1 <= act_p0;
            h_p1   <= h_cnt;
            v_p1   <= v_cnt;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
        end
    end

    // Stage 2: output registers, pixel data forced to zero in blanking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_out      <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            r_out       <= '0;
            g_out       <= '0;
            b_out       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            de_out                <= vld_p1;
            x_out                 <= vld_p1 ? h_p1 : '0;
            y_out                 <= vld_p1 ? v_p1 : '0;
            {r_out, g_out, b_out} <= vld_p1 ? rd_data : 12'h000;
            hsync                 <= hs_p1;
            vsync                 <= vs_p1;
            frame_start           <= vld_p1 && (h_p1 == '0) && (v_p1 == '0);
        end
    end

endmodule

// File: tb/tb_vga_fb_streamer.sv
// Directed bench for vga_fb_streamer on a shrunken 16x10 raster (8x6 active,
// 4x3 frame buffer) so several complete frames and bank swaps fit in a short run.
module tb_vga_fb_streamer;

    localparam int HR = 8, HFP = 2, HSW = 3, HBP = 3;
    localparam int VR = 6, VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = HR + HFP + HSW + HBP;   // 16
    localparam int VT = VR + VFP + VSW + VBP;   // 10
    localparam int FR = HT * VT;                // 160
    localparam int FBW = 4, FBH = 3;
    localparam int HSS = HR + HFP, HSE = HR + HFP + HSW;   // 10..12 low
    localparam int VSS = VR + VFP, VSE = VR + VFP + VSW;   // 7..8 low

    logic        clk = 1'b0;
    logic        reset;
    logic        swap_req;
    logic        swap_ack;
    logic        rd_bank;
    logic        rd_en;
    logic [17:0] rd_addr;
    logic [11:0] rd_data;
    logic        de_out;
    logic [9:0]  x_out, y_out;
    logic [3:0]  r_out, g_out, b_out;
    logic        hsync, vsync, frame_start;

    vga_fb_streamer #(
        .H_RES(HR), .V_RES(VR), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .FB_W(FBW), .FB_H(FBH), .ADDR_W(18)
    ) dut (
        .clk(clk), .reset(reset), .swap_req(swap_req), .swap_ack(swap_ack),
        .rd_bank(rd_bank), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .de_out(de_out), .x_out(x_out), .y_out(y_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pat(input logic [17:0] a);
        logic [11:0] t;
        t = a[11:0];
        return t * 12'd37 + 12'h5A3;
    endfunction

    // Synchronous memory: one clk read latency, junk when not enabled
    always @(posedge clk) rd_data <= rd_en ? pat(rd_addr) : 12'hFFF;

    int errors = 0;
    int checks = 0;

    int   k;
    logic exp_bank, exp_pend, exp_ack;
    logic vld1, vld2;
    int   idx1, idx2;
    logic [17:0] a1, a2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic act_at(input int idx);
        return ((idx % HT) < HR) && ((idx / HT) < VR);
    endfunction

    function automatic logic [17:0] exp_addr(input int idx, input logic bank);
        int a;
        if (!act_at(idx)) return 18'd0;
        a = (bank ? FBW * FBH : 0) + ((idx / HT) / 2) * FBW + (idx % HT) / 2;
        return 18'(a);
    endfunction

    task automatic check_all();
        int   cur;
        int   h2, v2;
        logic act2;
        cur  = k % FR;
        h2   = idx2 % HT;
        v2   = idx2 / HT;
        act2 = vld2 && act_at(idx2);
        chk("rd_bank", 32'(rd_bank), 32'(exp_bank));
        chk("swap_ack", 32'(swap_ack), 32'(exp_ack));
        chk("rd_en", 32'(rd_en), 32'(act_at(cur)));
        chk("rd_addr", 32'(rd_addr), 32'(exp_addr(cur, exp_bank)));
        chk("de_out", 32'(de_out), 32'(act2));
        chk("x_out", 32'(x_out), act2 ? h2 : 0);
        chk("y_out", 32'(y_out), act2 ? v2 : 0);
        chk("rgb", 32'({r_out, g_out, b_out}), act2 ? 32'(pat(a2)) : 32'd0);
        chk("hsync", 32'(hsync), 32'(!(vld2 && h2 >= HSS && h2 < HSE)));
        chk("vsync", 32'(vsync), 32'(!(vld2 && v2 >= VSS && v2 < VSE)));
        chk("frame_start", 32'(frame_start), 32'(act2 && idx2 == 0));
    endtask

    task automatic tick();
        int          pre;
        logic [17:0] a_now;
        logic        req;
        pre   = k % FR;
        a_now = exp_addr(pre, exp_bank);
        req   = swap_req;
        @(posedge clk);
        #1;
        vld2 = vld1; idx2 = idx1; a2 = a1;
        vld1 = 1'b1; idx1 = pre;  a1 = a_now;
        exp_ack = 1'b0;
        if (pre == FR - 1 && (exp_pend || req)) begin
            exp_bank = ~exp_bank;
            exp_pend = 1'b0;
            exp_ack  = 1'b1;
        end else if (req) begin
            exp_pend = 1'b1;
        end
        k++;
        check_all();
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    task automatic model_reset();
        k = 0; exp_bank = 1'b0; exp_pend = 1'b0; exp_ack = 1'b0;
        vld1 = 1'b0; vld2 = 1'b0; idx1 = 0; idx2 = 0; a1 = '0; a2 = '0;
    endtask

    initial begin
        reset = 1'b0;
        swap_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_de", 32'(de_out), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_rgb", 32'({r_out, g_out, b_out}), 0);
        chk("rst_bank", 32'(rd_bank), 0);
        chk("rst_ack", 32'(swap_ack), 0);
        chk("rst_rd_en", 32'(rd_en), 1);
        chk("rst_addr", 32'(rd_addr), 0);

        reset = 1'b1;
        chk("addr_0_0", 32'(rd_addr), 0);
        tick();
        chk("addr_1_0", 32'(rd_addr), 0);
        chk("de_k1", 32'(de_out), 0);
        tick();
        chk("addr_2_0", 32'(rd_addr), 1);
        chk("de_k2", 32'(de_out), 1);
        chk("fs_k2", 32'(frame_start), 1);
        chk("x_k2", 32'(x_out), 0);
        chk("y_k2", 32'(y_out), 0);
        run_to(16);
        chk("addr_0_1", 32'(rd_addr), 0);
        run_to(32);
        chk("addr_0_2", 32'(rd_addr), 4);
        run_to(87);
        chk("addr_7_5", 32'(rd_addr), 11);
        run_to(89);
        chk("x_7_5", 32'(x_out), 7);
        chk("y_7_5", 32'(y_out), 5);
        chk("rgb_7_5", 32'({r_out, g_out, b_out}), 32'(pat(18'd11)));

        // Mid-frame request: swap lands at the frame boundary
        run_to(50);
        pulse_swap();
        run_to(159);
        chk("bank_pre_eof", 32'(rd_bank), 0);
        chk("ack_pre_eof", 32'(swap_ack), 0);
        tick();
        chk("bank_after_swap", 32'(rd_bank), 1);
        chk("ack_after_swap", 32'(swap_ack), 1);
        chk("addr_bank1_first", 32'(rd_addr), 12);

        // Request on the first cycle of a frame plus a second one: one swap only
        pulse_swap();
        chk("ack_one_cycle", 32'(swap_ack), 0);
        run_to(250);
        pulse_swap();
        run_to(319);
        chk("bank_hold_frame", 32'(rd_bank), 1);
        tick();
        chk("bank_back_0", 32'(rd_bank), 0);
        chk("ack_double_req", 32'(swap_ack), 1);
        tick();
        chk("ack_single", 32'(swap_ack), 0);

        // Request coincident with the end-of-frame cycle
        run_to(479);
        pulse_swap();
        chk("bank_coincident", 32'(rd_bank), 1);
        chk("ack_coincident", 32'(swap_ack), 1);

        // Reset mid-frame with a swap pending
        run_to(490);
        pulse_swap();
        run_to(533);
        reset = 1'b0;
        #1;
        chk("mid_rst_de", 32'(de_out), 0);
        chk("mid_rst_rgb", 32'({r_out, g_out, b_out}), 0);
        chk("mid_rst_hsync", 32'(hsync), 1);
        chk("mid_rst_vsync", 32'(vsync), 1);
        chk("mid_rst_bank", 32'(rd_bank), 0);
        chk("mid_rst_addr", 32'(rd_addr), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_hold_de", 32'(de_out), 0);
        reset = 1'b1;
        model_reset();
        tick();
        chk("restart_de_k1", 32'(de_out), 0);
        tick();
        chk("restart_fs", 32'(frame_start), 1);
        chk("restart_x", 32'(x_out), 0);
        run_to(FR);
        chk("no_stale_swap_bank", 32'(rd_bank), 0);
        chk("no_stale_swap_ack", 32'(swap_ack), 0);
        run_to(FR + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
